axi_lite_reg_router: RTL



---
 rtl/axi_lite_reg_router_if.sv | 43 ++++
 rtl/axi_lite_reg_router.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/axi_lite_reg_router_if.sv
// Bundle of upstream register-interface and downstream port signals for axi_lite_reg_router.
// The router uses the slave modport; the environment driving requests and port responses uses master.
interface axi_lite_reg_router_if #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_PORTS      = 4,
    parameter int PORT_ADDR_BITS = 8
);
    // Upstream side
    logic                            i_reg_in_rdy;
    logic                            o_reg_in_ack_stb;
    logic [ADDR_WIDTH-1:0]           i_reg_address;
    logic [DATA_WIDTH-1:0]           i_reg_in_data;
    logic                            i_reg_out_req;
    logic                            o_reg_out_rdy_stb;
    logic [DATA_WIDTH-1:0]           o_reg_out_data;
    logic                            o_reg_invalid_addr;
    logic                            o_busy;

    // Downstream side
    logic [NUM_PORTS-1:0]            o_port_in_rdy;
    logic [NUM_PORTS-1:0]            i_port_in_ack_stb;
    logic [NUM_PORTS-1:0]            o_port_out_req;
    logic [NUM_PORTS-1:0]            i_port_out_rdy_stb;
    logic [NUM_PORTS*DATA_WIDTH-1:0] i_port_out_data;
    logic [NUM_PORTS-1:0]            i_port_invalid_addr;
    logic [PORT_ADDR_BITS-1:0]       o_port_address;
    logic [DATA_WIDTH-1:0]           o_port_in_data;

    modport slave (
        input  i_reg_in_rdy, i_reg_address, i_reg_in_data, i_reg_out_req,
        input  i_port_in_ack_stb, i_port_out_rdy_stb, i_port_out_data, i_port_invalid_addr,
        output o_reg_in_ack_stb, o_reg_out_rdy_stb, o_reg_out_data, o_reg_invalid_addr, o_busy,
        output o_port_in_rdy, o_port_out_req, o_port_address, o_port_in_data
    );

    modport master (
        output i_reg_in_rdy, i_reg_address, i_reg_in_data, i_reg_out_req,
        output i_port_in_ack_stb, i_port_out_rdy_stb, i_port_out_data, i_port_invalid_addr,
        input  o_reg_in_ack_stb, o_reg_out_rdy_stb, o_reg_out_data, o_reg_invalid_addr, o_busy,
        input  o_port_in_rdy, o_port_out_req, o_port_address, o_port_in_data
    );
endinterface

// File: rtl/axi_lite_reg_router.sv
// Routes one upstream register transaction at a time to one of NUM_PORTS register blocks,
// with a watchdog that turns a silent port into an error response.
module axi_lite_reg_router #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_PORTS      = 4,
    parameter int PORT_ADDR_BITS = 8,
    parameter int TIMEOUT        = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    axi_lite_reg_router_if.slave    bus,
    output logic [1:0]              dbg_state
);
    // Handshakes: upstream requests are levels held until the matching one-cycle strobe;
    // downstream requests are one-hot levels held until the selected port's one-cycle strobe.
    localparam int IDX_W = $clog2(NUM_PORTS);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RESPOND = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [IDX_W-1:0]          idx_q;
    logic                      write_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [NUM_PORTS-1:0]      in_rdy_q, in_rdy_nx;
    logic [NUM_PORTS-1:0]      out_req_q, out_req_nx;
    logic                      ack_q, ack_nx;
    logic                      rdy_q, rdy_nx;
    logic [DATA_WIDTH-1:0]     data_q, data_nx;
    logic                      inv_q, inv_nx;
    logic                      busy_q;
    logic [PORT_ADDR_BITS-1:0] paddr_q;
    logic [DATA_WIDTH-1:0]     pdata_q;

    logic [IDX_W-1:0]      dec_idx;
    logic                  dec_err;
    logic [NUM_PORTS-1:0]  dec_onehot;
    logic                  start;
    logic                  start_wr;
    logic                  sel_stb;
    logic                  timeout;
    logic [DATA_WIDTH-1:0] sel_data;

    assign dec_idx    = bus.i_reg_address[PORT_ADDR_BITS +: IDX_W];
    assign dec_err    = (int'(dec_idx) >= NUM_PORTS) ||
                        ((bus.i_reg_address >> (PORT_ADDR_BITS + IDX_W)) != '0);
    assign dec_onehot = NUM_PORTS'(1) << dec_idx;
    assign start      = (state == S_IDLE) && (bus.i_reg_in_rdy || bus.i_reg_out_req);
    assign start_wr   = bus.i_reg_in_rdy;
    assign sel_stb    = (state == S_WAIT) &&
                        (write_q ? bus.i_port_in_ack_stb[idx_q] : bus.i_port_out_rdy_stb[idx_q]);
    // A port strobe on the expiry edge still counts as a normal completion.
    assign timeout    = (state == S_WAIT) && (TIMEOUT != 0) && (cnt_q == CNT_LAST) && !sel_stb;
    assign sel_data   = bus.i_port_out_data[int'(idx_q) * DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (start) state_nx = dec_err ? S_RESPOND : S_WAIT;
            S_WAIT:    if (sel_stb || timeout) state_nx = S_RESPOND;
            S_RESPOND: state_nx = S_RELEASE;
            S_RELEASE: if (!bus.i_reg_in_rdy && !bus.i_reg_out_req) state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        in_rdy_nx  = in_rdy_q;
        out_req_nx = out_req_q;
        ack_nx     = 1'b0;
        rdy_nx     = 1'b0;
        data_nx    = data_q;
        inv_nx     = inv_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (dec_err) begin
                        ack_nx = start_wr;
                        rdy_nx = !start_wr;
                        inv_nx = 1'b1;
                        if (!start_wr) data_nx = '0;
                    end else if (start_wr) begin
                        in_rdy_nx = dec_onehot;
                    end else begin
                        out_req_nx = dec_onehot;
                    end
                end
            end
            S_WAIT: begin
                if (sel_stb || timeout) begin
                    in_rdy_nx  = '0;
                    out_req_nx = '0;
                    ack_nx     = write_q;
                    rdy_nx     = !write_q;
                    inv_nx     = sel_stb ? bus.i_port_invalid_addr[idx_q] : 1'b1;
                    if (!write_q) data_nx = sel_stb ? sel_data : '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q     <= '0;
            write_q   <= 1'b0;
            cnt_q     <= '0;
            in_rdy_q  <= '0;
            out_req_q <= '0;
            ack_q     <= 1'b0;
            rdy_q     <= 1'b0;
            data_q    <= '0;
            inv_q     <= 1'b0;
            busy_q    <= 1'b0;
            paddr_q   <= '0;
            pdata_q   <= '0;
        end else begin
            in_rdy_q  <= in_rdy_nx;
            out_req_q <= out_req_nx;
            ack_q     <= ack_nx;
            rdy_q     <= rdy_nx;
            data_q    <= data_nx;
            inv_q     <= inv_nx;
            busy_q    <= (state_nx != S_IDLE);
            if (start) begin
                idx_q   <= dec_idx;
                write_q <= start_wr;
                cnt_q   <= '0;
                // Shared port buses only move for transactions that reach a port.
                if (!dec_err) begin
                    paddr_q <= bus.i_reg_address[PORT_ADDR_BITS-1:0];
                    pdata_q <= bus.i_reg_in_data;
                end
            end else if (state == S_WAIT) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.o_port_in_rdy      = in_rdy_q;
    assign bus.o_port_out_req     = out_req_q;
    assign bus.o_reg_in_ack_stb   = ack_q;
    assign bus.o_reg_out_rdy_stb  = rdy_q;
    assign bus.o_reg_out_data     = data_q;
    assign bus.o_reg_invalid_addr = inv_q;
    assign bus.o_busy             = busy_q;
    assign bus.o_port_address     = paddr_q;
    assign bus.o_port_in_data     = pdata_q;
    assign dbg_state              = state;
endmodule
